// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants for the instruction-fetch stage: bubble
//               instruction, default reset PC, PC increment and the FSM
//               state encodings used by if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // addi x0,x0,0 -- architectural no-op used as the IF/ID bubble
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    // Default fetch address after reset
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    // Sequential fetch stride (one 32-bit instruction)
    localparam logic [31:0] c_pc_incr   = 32'd4;

    // Fetch FSM state encodings
    localparam int unsigned c_state_w   = 2;
    localparam logic [1:0]  c_st_boot   = 2'd0;
    localparam logic [1:0]  c_st_run    = 2'd1;
    localparam logic [1:0]  c_st_halt   = 2'd2;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register holding pc / instr / valid for the
//               decoder. Supports load, hold and flush.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load        - capture i_pc/i_instr, mark valid
//               i_flush       - replace instr by bubble, clear valid, keep pc
//               i_pc, i_instr - fetched PC and instruction word
//               o_pc, o_instr, o_valid - registered IF/ID contents
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    // Flush wins over load so a redirect can never let a wrong-path
    // instruction slip into the decoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC (driven to instr_mem,
//               which reads combinationally), registers the returned
//               instruction plus its PC into IF/ID, and handles stall,
//               redirect-with-flush and a sticky misaligned-target fault.
// Ports       : clk, rst                        - clock, sync active-high reset
//               PC                              - fetch address to instr_mem
//               Instruction_Code                - instr_mem read data for PC
//               stall                           - hold PC and IF/ID
//               redirect_valid, redirect_target - taken branch/jump
//               if_id_pc, if_id_instr, if_id_valid - IF/ID contents
//               fetch_fault, fault_pc           - sticky misaligned-target flag
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_reset_pc,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    input  logic [31:0] Instruction_Code,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;

    logic [31:0] r_pc;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic w_misaligned;
    logic w_pc_redirect;   // load PC from redirect_target
    logic w_pc_incr;       // advance PC sequentially
    logic w_load;          // capture fetch into IF/ID
    logic w_flush;         // bubble IF/ID
    logic w_fault_set;     // record misaligned target

    assign w_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_boot: w_state_next = w_misaligned ? c_st_halt : c_st_run;
            c_st_run:  w_state_next = w_misaligned ? c_st_halt : c_st_run;
            c_st_halt: w_state_next = c_st_halt;
            default:   w_state_next = c_st_halt;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // Redirect takes priority over stall. BOOT never fetches: it only
    // spends the instr_mem init cycle, optionally absorbing a redirect.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_redirect = 1'b0;
        w_pc_incr     = 1'b0;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        w_fault_set   = 1'b0;
        case (r_state)
            c_st_boot: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (w_misaligned) begin
                        w_fault_set = 1'b1;
                    end else begin
                        w_pc_redirect = 1'b1;
                    end
                end
            end
            c_st_run: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (w_misaligned) begin
                        w_fault_set = 1'b1;
                    end else begin
                        w_pc_redirect = 1'b1;
                    end
                end else if (!stall) begin
                    w_load    = 1'b1;
                    w_pc_incr = 1'b1;
                end
            end
            default: begin
                // HALT: everything frozen until reset
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and fault registers (PC+4 wraps naturally at 32 bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0000_0000;
        end else begin
            if (w_pc_redirect) begin
                r_pc <= redirect_target;
            end else if (w_pc_incr) begin
                r_pc <= r_pc + c_pc_incr;
            end
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (Instruction_Code),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr),
        .o_valid (if_id_valid)
    );

    assign PC          = r_pc;
    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed testbench for if_stage. Each vector drives one
//               cycle of inputs and queues the hand-computed register state
//               expected after that clock edge; an independent monitor pops
//               and compares one entry per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic        id_valid;
        logic        fault;
        logic [31:0] fault_pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;

    if_stage u_dut (
        .clk              (clk),
        .rst              (rst),
        .PC               (PC),
        .Instruction_Code (Instruction_Code),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .fetch_fault      (fetch_fault),
        .fault_pc         (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory stub: three program words, every
    // other address returns PC ^ 0xDEAD0000 so fetched data is traceable.
    always_comb begin
        case (PC)
            32'h0000_0000: Instruction_Code = 32'h0050_0093;
            32'h0000_0004: Instruction_Code = 32'h00A0_0113;
            32'h0000_0008: Instruction_Code = 32'h0020_81B3;
            default:       Instruction_Code = PC ^ 32'hDEAD_0000;
        endcase
    end

    task automatic vec(input string nm, input logic r, input logic st,
                       input logic rv, input logic [31:0] rt,
                       input logic [31:0] e_pc, input logic [31:0] e_ipc,
                       input logic [31:0] e_instr, input logic e_v,
                       input logic e_f, input logic [31:0] e_fpc);
        exp_t e;
        @(negedge clk);
        rst             = r;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        e.name     = nm;
        e.pc       = e_pc;
        e.id_pc    = e_ipc;
        e.id_instr = e_instr;
        e.id_valid = e_v;
        e.fault    = e_f;
        e.fault_pc = e_fpc;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, sampled 1 time unit after.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (PC !== e.pc) begin
                    n_err++;
                    $display("FAIL %s PC: got %h want %h", e.name, PC, e.pc);
                end
                if (if_id_pc !== e.id_pc) begin
                    n_err++;
                    $display("FAIL %s if_id_pc: got %h want %h", e.name, if_id_pc, e.id_pc);
                end
                if (if_id_instr !== e.id_instr) begin
                    n_err++;
                    $display("FAIL %s if_id_instr: got %h want %h", e.name, if_id_instr, e.id_instr);
                end
                if (if_id_valid !== e.id_valid) begin
                    n_err++;
                    $display("FAIL %s if_id_valid: got %b want %b", e.name, if_id_valid, e.id_valid);
                end
                if (fetch_fault !== e.fault) begin
                    n_err++;
                    $display("FAIL %s fetch_fault: got %b want %b", e.name, fetch_fault, e.fault);
                end
                if (fault_pc !== e.fault_pc) begin
                    n_err++;
                    $display("FAIL %s fault_pc: got %h want %h", e.name, fault_pc, e.fault_pc);
                end
            end
        end
    end

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        int budget;
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        //   name        rst st rv target          PC            if_id_pc      instr         v   f   fault_pc
        // Reset then boot and sequential fetch
        vec("rst0",      1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("rst1",      1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("boot",      0, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("run0",      0, 0, 0, 32'h0,         32'h4,        32'h0,        32'h00500093, 1,  0,  32'h0);
        vec("run4",      0, 0, 0, 32'h0,         32'h8,        32'h4,        32'h00A00113, 1,  0,  32'h0);
        // Stall while PC=8
        vec("stall_a",   0, 1, 0, 32'h0,         32'h8,        32'h4,        32'h00A00113, 1,  0,  32'h0);
        vec("stall_b",   0, 1, 0, 32'h0,         32'h8,        32'h4,        32'h00A00113, 1,  0,  32'h0);
        vec("resume8",   0, 0, 0, 32'h0,         32'hC,        32'h8,        32'h002081B3, 1,  0,  32'h0);
        vec("runC",      0, 0, 0, 32'h0,         32'h10,       32'hC,        32'hDEAD000C, 1,  0,  32'h0);
        // Redirect beats stall
        vec("redir_st",  0, 1, 1, 32'h24,        32'h24,       32'hC,        NOP,          0,  0,  32'h0);
        vec("run24",     0, 0, 0, 32'h0,         32'h28,       32'h24,       32'hDEAD0024, 1,  0,  32'h0);
        // PC wrap
        vec("redir_top", 0, 0, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h24,       NOP,          0,  0,  32'h0);
        vec("wrap",      0, 0, 0, 32'h0,         32'h0,        32'hFFFFFFFC, 32'h2152FFFC, 1,  0,  32'h0);
        vec("run0b",     0, 0, 0, 32'h0,         32'h4,        32'h0,        32'h00500093, 1,  0,  32'h0);
        vec("run4b",     0, 0, 0, 32'h0,         32'h8,        32'h4,        32'h00A00113, 1,  0,  32'h0);
        vec("run8b",     0, 0, 0, 32'h0,         32'hC,        32'h8,        32'h002081B3, 1,  0,  32'h0);
        vec("runCb",     0, 0, 0, 32'h0,         32'h10,       32'hC,        32'hDEAD000C, 1,  0,  32'h0);
        // Reset mid-run at PC=0x10
        vec("rst_mid",   1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("boot2",     0, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("run0c",     0, 0, 0, 32'h0,         32'h4,        32'h0,        32'h00500093, 1,  0,  32'h0);
        // Misaligned redirect, sticky halt
        vec("misal",     0, 0, 1, 32'h22,        32'h4,        32'h0,        NOP,          0,  1,  32'h22);
        vec("halt_rd",   0, 0, 1, 32'h40,        32'h4,        32'h0,        NOP,          0,  1,  32'h22);
        vec("halt_rd2",  0, 1, 1, 32'h31,        32'h4,        32'h0,        NOP,          0,  1,  32'h22);
        vec("halt_idle", 0, 0, 0, 32'h0,         32'h4,        32'h0,        NOP,          0,  1,  32'h22);
        vec("rst_flt",   1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("boot3",     0, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        // Aligned redirect during BOOT
        vec("rst4",      1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("boot_rd",   0, 0, 1, 32'h80,        32'h80,       32'h0,        NOP,          0,  0,  32'h0);
        vec("run80",     0, 0, 0, 32'h0,         32'h84,       32'h80,       32'hDEAD0080, 1,  0,  32'h0);
        // Misaligned redirect during BOOT
        vec("rst5",      1, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  0,  32'h0);
        vec("boot_mis",  0, 0, 1, 32'h6,         32'h0,        32'h0,        NOP,          0,  1,  32'h6);
        vec("halt_run",  0, 0, 0, 32'h0,         32'h0,        32'h0,        NOP,          0,  1,  32'h6);

        @(negedge clk);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
